// File: rtl/rv32i_dtcm.sv
// Data TCM: the core port gets zero-latency reads and writes, and a host port uses valid/ready handshakes.
// Core reads are combinational; a host response is registered and appears one cycle after acceptance.
// A core write in the acceptance cycle stalls the host request, and the host holds RESP until host_rsp_ready.
module rv32i_dtcm #(
    parameter int                  WORD_WTH   = 32,
    parameter int                  ADDR_WTH   = 32,
    parameter int                  DEPTH_LOG2 = 10,
    parameter logic [ADDR_WTH-1:0] BASE_ADDR  = '0
) (
    input  logic                clk,
    input  logic                rst,
    // core data-TCM port
    input  logic [ADDR_WTH-1:0] dtcm_addr,
    input  logic                dtcm_we,
    input  logic [WORD_WTH-1:0] dtcm_wdata,
    output logic [WORD_WTH-1:0] dtcm_rdata,
    // host request channel
    input  logic                host_req_valid,
    output logic                host_req_ready,
    input  logic                host_req_we,
    input  logic [ADDR_WTH-1:0] host_req_addr,
    input  logic [WORD_WTH-1:0] host_req_wdata,
    // host response channel
    output logic                host_rsp_valid,
    input  logic                host_rsp_ready,
    output logic [WORD_WTH-1:0] host_rsp_rdata,
    output logic                host_rsp_err,
    // sticky flag for illegal core writes
    output logic                core_err
);

    localparam int NWORDS = 1 << DEPTH_LOG2;
    // This is one bit wider than an address, so a window that reaches the top of the address space still compares correctly.
    localparam logic [ADDR_WTH:0] SPAN_BYTES = (ADDR_WTH+1)'(4) << DEPTH_LOG2;

    typedef struct packed {
        logic                  legal;
        logic                  in_range;
        logic                  misaligned;
        logic [DEPTH_LOG2-1:0] idx;
    } dec_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // Both ports share one decode. The offset wraps, so an address below BASE_ADDR also needs the explicit >= test.
    function automatic dec_t decode(input logic [ADDR_WTH-1:0] addr);
        logic [ADDR_WTH-1:0] off;
        dec_t                d;
        off          = addr - BASE_ADDR;
        d.in_range   = (addr >= BASE_ADDR) && ({1'b0, off} < SPAN_BYTES);
        d.misaligned = (addr[1:0] != 2'b00);
        d.idx        = off[DEPTH_LOG2+1:2];
        d.legal      = d.in_range && !d.misaligned;
        return d;
    endfunction

    // The storage array is not reset; its contents survive reset.
    logic [WORD_WTH-1:0]   mem [NWORDS];

    dec_t                  core_dec;
    dec_t                  host_dec;
    logic                  host_acc;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_widx;
    logic [WORD_WTH-1:0]   mem_wdat;

    state_e                state_q,     state_d;
    logic [WORD_WTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic                  core_err_q,  core_err_d;

    assign core_dec = decode(dtcm_addr);
    assign host_dec = decode(host_req_addr);

    // The ready path depends only on reset, the core write strobe and the FSM state. It does not depend on host inputs.
    assign host_req_ready = rst && !dtcm_we && (state_q == ST_IDLE);
    assign host_acc       = host_req_valid && host_req_ready;

    // The core read is zero-latency. An out-of-window read returns zero, and the byte offset is ignored.
    always_comb begin
        dtcm_rdata = '0;
        if (core_dec.in_range) begin
            dtcm_rdata = mem[core_dec.idx];
        end
    end

    // This selects the single write port. A host write is accepted only when no core write is present, so the two never collide.
    always_comb begin
        mem_we   = 1'b0;
        mem_widx = core_dec.idx;
        mem_wdat = dtcm_wdata;
        if (rst) begin
            if (dtcm_we && core_dec.legal) begin
                mem_we = 1'b1;
            end else if (host_acc && host_req_we && host_dec.legal) begin
                mem_we   = 1'b1;
                mem_widx = host_dec.idx;
                mem_wdat = host_req_wdata;
            end
        end
    end

    // This is the memory write. A host read sampled on the same edge still sees the pre-edge word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdat;
        end
    end

    // This block computes the host FSM next state, the captured response and the sticky core error.
    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        core_err_d  = core_err_q;

        if (dtcm_we && !core_dec.legal) begin
            core_err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (host_acc) begin
                    state_d     = ST_RESP;
                    rsp_err_d   = !host_dec.legal;
                    rsp_rdata_d = '0;
                    if (host_dec.legal && !host_req_we) begin
                        rsp_rdata_d = mem[host_dec.idx];
                    end
                end
            end
            ST_RESP: begin
                // No new request is accepted in the cycle of the response handshake, so the next request lands at least one cycle later.
                if (host_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // These are the state registers. A synchronous reset drops any pending response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            core_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            core_err_q  <= core_err_d;
        end
    end

    assign host_rsp_valid = (state_q == ST_RESP);
    assign host_rsp_rdata = rsp_rdata_q;
    assign host_rsp_err   = rsp_err_q;
    assign core_err       = core_err_q;

endmodule
